// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the AHB-Lite GPIO controller: register offsets,
// AHB encodings and the byte-strobe helper.
package gpio_ctrl_pkg;

   typedef enum logic [2:0] {
      ADDR_DOUT     = 3'd0,
      ADDR_OEB      = 3'd1,
      ADDR_DIN      = 3'd2,
      ADDR_IRQ_EN   = 3'd3,
      ADDR_IRQ_POL  = 3'd4,
      ADDR_IRQ_STAT = 3'd5,
      ADDR_DOUT_SET = 3'd6,
      ADDR_DOUT_CLR = 3'd7
   } reg_off_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
      case (size)
         HSIZE_BYTE: byte_strobe = 4'b0001 << addr;
         HSIZE_HALF: byte_strobe = addr[1] ? 4'b1100 : 4'b0011;
         default:    byte_strobe = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_gpio_ctrl_if.sv
// AHB-Lite slave bus bundle for the GPIO controller.
interface ahb_gpio_ctrl_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRDATA
   );
endinterface

// File: rtl/gpio_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-high reset.
module gpio_sync #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite GPIO controller: output/enable registers, synchronized inputs and
// optional edge interrupts (compiled in when GPIO_IRQ_EN is defined).
module ahb_gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int unsigned GPIO_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   ahb_gpio_ctrl_if.slave    bus,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oeb,
   output logic              irq
);
   logic              dp_valid;
   logic              dp_write;
   logic [4:0]        dp_addr;
   logic [2:0]        dp_size;
   logic              addr_ok;
   logic              wr;
   reg_off_e          off;
   logic [3:0]        strb;
   logic [31:0]       bmask;
   logic [GPIO_W-1:0] wmask;
   logic [GPIO_W-1:0] wdata;
   logic [GPIO_W-1:0] dout;
   logic [GPIO_W-1:0] oeb;
   logic [GPIO_W-1:0] din;
   logic [31:0]       rd;
   logic              unused_bits;

   assign unused_bits = ^{bus.HADDR[31:5], bus.HTRANS[0]};
   assign addr_ok     = bus.HSEL & bus.HREADY & bus.HTRANS[1];

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_size  <= '0;
      end else begin
         dp_valid <= addr_ok;
         if (addr_ok) begin
            dp_write <= bus.HWRITE;
            dp_addr  <= bus.HADDR[4:0];
            dp_size  <= bus.HSIZE;
         end
      end
   end

   assign wr  = dp_valid & dp_write;
   assign off = reg_off_e'(dp_addr[4:2]);

   always_comb begin
      strb = byte_strobe(dp_size, dp_addr[1:0]);
      for (int unsigned i = 0; i < 4; i++) bmask[i*8 +: 8] = {8{strb[i]}};
      wmask = bmask[GPIO_W-1:0];
      wdata = bus.HWDATA[GPIO_W-1:0] & wmask;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dout <= '0;
         oeb  <= '1;
      end else if (wr) begin
         case (off)
            ADDR_DOUT:     dout <= (dout & ~wmask) | wdata;
            ADDR_OEB:      oeb  <= (oeb & ~wmask) | wdata;
            ADDR_DOUT_SET: dout <= dout | wdata;
            ADDR_DOUT_CLR: dout <= dout & ~wdata;
            default: ;
         endcase
      end
   end

   assign gpio_out = dout;
   assign gpio_oeb = oeb;

   gpio_sync #(.W(GPIO_W)) u_sync (
      .clk (HCLK),
      .rst (HRESET),
      .d   (gpio_in),
      .q   (din)
   );

`ifdef GPIO_IRQ_EN
   logic [GPIO_W-1:0] irq_en;
   logic [GPIO_W-1:0] irq_pol;
   logic [GPIO_W-1:0] irq_stat;
   logic [GPIO_W-1:0] din_q;
   logic [GPIO_W-1:0] edge_hit;
   logic [GPIO_W-1:0] w1c;

   always_comb begin
      edge_hit = (din & ~din_q & ~irq_pol) | (~din & din_q & irq_pol);
      w1c      = (wr && off == ADDR_IRQ_STAT) ? wdata : '0;
   end

   // Edge set is OR-ed after the clear so a coincident edge survives the W1C.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         irq_en   <= '0;
         irq_pol  <= '0;
         irq_stat <= '0;
         din_q    <= '0;
      end else begin
         din_q    <= din;
         irq_stat <= (irq_stat & ~w1c) | edge_hit;
         if (wr) begin
            case (off)
               ADDR_IRQ_EN:  irq_en  <= (irq_en & ~wmask) | wdata;
               ADDR_IRQ_POL: irq_pol <= (irq_pol & ~wmask) | wdata;
               default: ;
            endcase
         end
      end
   end

   assign irq = |(irq_stat & irq_en);
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd = '0;
      case (off)
         ADDR_DOUT:     rd[GPIO_W-1:0] = dout;
         ADDR_OEB:      rd[GPIO_W-1:0] = oeb;
         ADDR_DIN:      rd[GPIO_W-1:0] = din;
`ifdef GPIO_IRQ_EN
         ADDR_IRQ_EN:   rd[GPIO_W-1:0] = irq_en;
         ADDR_IRQ_POL:  rd[GPIO_W-1:0] = irq_pol;
         ADDR_IRQ_STAT: rd[GPIO_W-1:0] = irq_stat;
`endif
         default: ;
      endcase
      bus.HRDATA = (dp_valid & ~dp_write) ? rd : '0;
   end

   assign bus.HREADYOUT = 1'b1;
endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Directed, table-driven bench for ahb_gpio_ctrl; the interrupt scenarios run
// only when GPIO_IRQ_EN is defined, otherwise the compiled-out behaviour is checked.
module tb_ahb_gpio_ctrl;
   import gpio_ctrl_pkg::*;

`ifdef GPIO_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oeb;
   logic        irq;

   ahb_gpio_ctrl_if bus ();

   ahb_gpio_ctrl #(.GPIO_W(32)) dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oeb (gpio_oeb),
      .irq      (irq)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;    // write data, or expected read data
      logic [31:0] exp_out;
      logic [31:0] exp_oeb;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [31:0] o, input logic [31:0] e,
                      input string name);
      vec_t v;
      v.wr = wr; v.addr = a; v.size = sz; v.data = d;
      v.exp_out = o; v.exp_oeb = e; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      bus.HREADY = 1'b1;
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      bus.HSEL   = 1'b1;
      bus.HTRANS = HTRANS_NONSEQ;
      bus.HWRITE = wr;
      bus.HADDR  = a;
      bus.HSIZE  = sz;
      bus.HREADY = 1'b1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      @(negedge HCLK);
      addr_phase(1'b1, a, sz);
      @(negedge HCLK);
      check("hrdata_zero_on_write", bus.HRDATA, 32'h0);
      bus.HWDATA = d;
      idle();
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] rd);
      @(negedge HCLK);
      addr_phase(1'b0, a, sz);
      @(negedge HCLK);
      rd = bus.HRDATA;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      bit          got;

      HRESET = 1'b1;
      gpio_in = '0;
      bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = '0;
      idle();

      // Vector table: register map, strobes, set/clear, read-only and compiled-out offsets.
      add(0, 32'h04, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, "rd_oeb_reset");
      add(1, 32'h01, HSIZE_BYTE, 32'hA5A5_A5A5, 32'h0000_A500, 32'hFFFF_FFFF, "wr_dout_byte1");
      add(0, 32'h00, HSIZE_WORD, 32'h0000_A500, 32'h0000_A500, 32'hFFFF_FFFF, "rd_dout");
      add(1, 32'h02, HSIZE_HALF, 32'hBEEF_1234, 32'hBEEF_A500, 32'hFFFF_FFFF, "wr_dout_half_hi");
      add(1, 32'h00, HSIZE_WORD, 32'h0000_000F, 32'h0000_000F, 32'hFFFF_FFFF, "wr_dout_word");
      add(1, 32'h18, HSIZE_WORD, 32'h0000_00F0, 32'h0000_00FF, 32'hFFFF_FFFF, "wr_dout_set");
      add(1, 32'h1C, HSIZE_WORD, 32'h0000_0003, 32'h0000_00FC, 32'hFFFF_FFFF, "wr_dout_clr");
      add(0, 32'h18, HSIZE_WORD, 32'h0,         32'h0000_00FC, 32'hFFFF_FFFF, "rd_dout_set");
      add(0, 32'h1C, HSIZE_WORD, 32'h0,         32'h0000_00FC, 32'hFFFF_FFFF, "rd_dout_clr");
      add(1, 32'h04, HSIZE_WORD, 32'h0000_FFFF, 32'h0000_00FC, 32'h0000_FFFF, "wr_oeb_word");
      add(1, 32'h07, HSIZE_BYTE, 32'h1234_5678, 32'h0000_00FC, 32'h1200_FFFF, "wr_oeb_byte3");
      add(1, 32'h08, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0000_00FC, 32'h1200_FFFF, "wr_din_ignored");
      add(0, 32'h08, HSIZE_WORD, 32'h0,         32'h0000_00FC, 32'h1200_FFFF, "rd_din");
      add(1, 32'h0C, HSIZE_WORD, 32'h0000_0003, 32'h0000_00FC, 32'h1200_FFFF, "wr_irq_en");
      add(0, 32'h0C, HSIZE_WORD, IRQ_ON ? 32'h3 : 32'h0, 32'h0000_00FC, 32'h1200_FFFF, "rd_irq_en");
      add(1, 32'h10, HSIZE_WORD, 32'h0000_000A, 32'h0000_00FC, 32'h1200_FFFF, "wr_irq_pol");
      add(0, 32'h10, HSIZE_WORD, IRQ_ON ? 32'hA : 32'h0, 32'h0000_00FC, 32'h1200_FFFF, "rd_irq_pol");
      add(0, 32'h14, HSIZE_WORD, 32'h0,         32'h0000_00FC, 32'h1200_FFFF, "rd_irq_stat");

      repeat (3) @(negedge HCLK);
      check("rst_hold_oeb", gpio_oeb, 32'hFFFF_FFFF);
      check("rst_hold_out", gpio_out, 32'h0);
      check("rst_hold_irq", {31'h0, irq}, 32'h0);
      check("rst_hold_hrdata", bus.HRDATA, 32'h0);
      check("rst_hold_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
      HRESET = 1'b0;
      @(negedge HCLK);
      check("post_rst_oeb", gpio_oeb, 32'hFFFF_FFFF);
      check("post_rst_out", gpio_out, 32'h0);
      check("post_rst_irq", {31'h0, irq}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].size, vecs[i].data);
         end else begin
            bus_read(vecs[i].addr, vecs[i].size, rd);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].data);
         end
         @(negedge HCLK);
         check({vecs[i].name, "_out"}, gpio_out, vecs[i].exp_out);
         check({vecs[i].name, "_oeb"}, gpio_oeb, vecs[i].exp_oeb);
      end

      // Back-to-back write then read of DOUT with no idle cycle between.
      @(negedge HCLK);
      addr_phase(1'b1, 32'h00, HSIZE_WORD);
      @(negedge HCLK);
      check("b2b_hreadyout_a", {31'h0, bus.HREADYOUT}, 32'h1);
      bus.HWDATA = 32'h1234_5678;
      addr_phase(1'b0, 32'h00, HSIZE_WORD);
      bus.HTRANS = HTRANS_SEQ;
      @(negedge HCLK);
      check("b2b_hreadyout_d", {31'h0, bus.HREADYOUT}, 32'h1);
      check("b2b_rdata", bus.HRDATA, 32'h1234_5678);
      idle();

      // Input synchronizer latency: new pad value visible on DIN two edges later.
      @(negedge HCLK);
      gpio_in = 32'h8000_0010;
      addr_phase(1'b0, 32'h08, HSIZE_WORD);
      @(negedge HCLK);
      check("din_lat_1", bus.HRDATA, 32'h0);
      @(negedge HCLK);
      check("din_lat_2", bus.HRDATA, 32'h8000_0010);
      idle();

      // Address phases that must not be acted on: HREADY low, HSEL low, BUSY.
      for (int v = 0; v < 3; v++) begin
         @(negedge HCLK);
         addr_phase(1'b1, 32'h00, HSIZE_WORD);
         if (v == 0) bus.HREADY = 1'b0;
         if (v == 1) bus.HSEL = 1'b0;
         if (v == 2) bus.HTRANS = HTRANS_BUSY;
         @(negedge HCLK);
         bus.HWDATA = 32'hFFFF_FFFF;
         idle();
         @(negedge HCLK);
         check($sformatf("no_xfer_%0d", v), gpio_out, 32'h1234_5678);
      end

`ifdef GPIO_IRQ_EN
      // Pre-existing edges (bits 31,4 and a rising bit 2) are cleared before arming.
      @(negedge HCLK);
      gpio_in[2] = 1'b1;
      repeat (4) @(negedge HCLK);
      bus_write(32'h14, HSIZE_WORD, 32'hFFFF_FFFF);
      bus_write(32'h10, HSIZE_WORD, 32'h0000_0004);
      bus_write(32'h0C, HSIZE_WORD, 32'h0000_0001);
      @(negedge HCLK);
      check("irq_armed_low", {31'h0, irq}, 32'h0);
      bus_read(32'h14, HSIZE_WORD, rd);
      check("irq_stat_cleared", rd, 32'h0);

      @(negedge HCLK);
      gpio_in[0] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge HCLK);
         if (irq) got = 1'b1;
      end
      check("irq_rise_within_4", {31'h0, got}, 32'h1);
      bus_read(32'h14, HSIZE_WORD, rd);
      check("irq_stat_bit0", rd, 32'h1);
      bus_write(32'h14, HSIZE_WORD, 32'h1);
      @(negedge HCLK);
      check("irq_after_w1c", {31'h0, irq}, 32'h0);

      // Falling edge on bit 2 timed to coincide with a W1C of bit 2.
      @(negedge HCLK);
      gpio_in[2] = 1'b0;
      @(negedge HCLK);
      addr_phase(1'b1, 32'h14, HSIZE_WORD);
      @(negedge HCLK);
      bus.HWDATA = 32'h4;
      idle();
      bus_read(32'h14, HSIZE_WORD, rd);
      check("irq_collision_set_wins", rd, 32'h4);
`else
      @(negedge HCLK);
      gpio_in[0] = 1'b1;
      repeat (4) @(negedge HCLK);
      check("irq_tied_low", {31'h0, irq}, 32'h0);
      bus_read(32'h14, HSIZE_WORD, rd);
      check("irq_stat_absent", rd, 32'h0);
`endif

      // Reset during a write data phase: the write must be dropped.
      @(negedge HCLK);
      addr_phase(1'b1, 32'h00, HSIZE_WORD);
      @(negedge HCLK);
      bus.HWDATA = 32'hDEAD_BEEF;
      idle();
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      check("midrst_out", gpio_out, 32'h0);
      check("midrst_oeb", gpio_oeb, 32'hFFFF_FFFF);
      @(negedge HCLK);
      check("midrst_out_after", gpio_out, 32'h0);
      bus_read(32'h00, HSIZE_WORD, rd);
      check("midrst_rd_dout", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
